// File: rtl/ft60x_stream_engine.sv
// ft60x_stream_engine: data engine between the FT60x bus-side module and the
// host logic. It offers loopback through a FWFT FIFO, a counter source, a
// counter checker and loopback+check, with a run/drain FSM and status counters.
//
// Handshake rule for both streams: a word moves on the rising ftdi_clk edge
// where valid && ready are both high. tx_valid never drops, and tx_data/tx_be
// never change, while a word is waiting for tx_ready.
module ft60x_stream_engine #(
   parameter int DATA_W = 16,
   parameter int BE_W   = DATA_W / 8,
   parameter int DEPTH  = 512,
   parameter int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              ftdi_clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   input  logic [BE_W-1:0]   rx_be,
   output logic              rx_ready,
   output logic              tx_valid,
   output logic [DATA_W-1:0] tx_data,
   output logic [BE_W-1:0]   tx_be,
   input  logic              tx_ready,
   output logic              busy,
   output logic [LVL_W-1:0]  level,
   output logic [31:0]       rx_word_cnt,
   output logic [31:0]       tx_word_cnt,
   output logic [15:0]       err_cnt,
   output logic [1:0]        fsm_state
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [1:0] MODE_LOOP = 2'd0;
   localparam logic [1:0] MODE_SRC  = 2'd1;
   localparam logic [1:0] MODE_CHK  = 2'd2;
   localparam logic [1:0] MODE_LCHK = 2'd3;

   localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0]  ONE_LVL  = LVL_W'(1);
   localparam logic [AW-1:0]     ONE_PTR  = AW'(1);
   localparam logic [DATA_W-1:0] ONE_D    = DATA_W'(1);

   logic [1:0]               state, state_nxt;
   logic [1:0]               mode_q;
   logic [DATA_W+BE_W-1:0]   mem [DEPTH];
   logic [AW-1:0]            wr_ptr, rd_ptr;
   logic [LVL_W-1:0]         cnt;
   logic [DATA_W-1:0]        gen, exp_word, be_mask;
   logic                     pend;
   logic                     fifo_mode, full, empty;
   logic                     rx_hs, tx_hs, push, pop;
   logic                     chk_en, mismatch, run_entry;

   // Modes 0 and 3 route data through the FIFO
   assign fifo_mode = (mode_q == MODE_LOOP) || (mode_q == MODE_LCHK);
   assign full      = (cnt == FULL_LVL);
   assign empty     = (cnt == '0);
   assign rx_hs     = rx_valid && rx_ready;
   assign tx_hs     = tx_valid && tx_ready;
   assign push      = rx_hs && fifo_mode;
   assign pop       = tx_hs && fifo_mode;
   assign run_entry = (state == ST_IDLE) && enable;
   assign busy      = (state != ST_IDLE);
   assign level     = cnt;
   assign fsm_state = state;

   // Per-byte mask from the received byte enables
   always_comb begin
      be_mask = '0;
      for (int i = 0; i < BE_W; i++) begin
         be_mask[8*i +: 8] = {8{rx_be[i]}};
      end
   end

   // Checker is active on accepted words in check modes with any byte enabled
   assign chk_en   = rx_hs && ((mode_q == MODE_CHK) || (mode_q == MODE_LCHK)) && (|rx_be);
   assign mismatch = |((rx_data ^ exp_word) & be_mask);

   // Handshake outputs per state and mode
   always_comb begin
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      case (state)
         ST_RUN: begin
            case (mode_q)
               MODE_SRC: begin
                  rx_ready = 1'b1;
                  tx_valid = 1'b1;
               end
               MODE_CHK: rx_ready = 1'b1;
               default: begin
                  rx_ready = !full;
                  tx_valid = !empty;
               end
            endcase
         end
         ST_DRAIN: begin
            if (fifo_mode) tx_valid = !empty;
            else if (mode_q == MODE_SRC) tx_valid = pend;
         end
         default: ;
      endcase
   end

   // Transmit word: generator while a source run is active, else FIFO head
   always_comb begin
      tx_data = '0;
      tx_be   = '0;
      if ((mode_q == MODE_SRC) && (state != ST_IDLE)) begin
         tx_data = gen;
         tx_be   = '1;
      end else if (!empty) begin
         {tx_be, tx_data} = mem[rd_ptr];
      end
   end

   // Run-control next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (enable) state_nxt = ST_RUN;
         ST_RUN:   if (!enable) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (fifo_mode) begin
               if (empty) state_nxt = ST_IDLE;
            end else if (mode_q == MODE_SRC) begin
               if (!pend || tx_ready) state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FIFO storage; contents need no reset because occupancy gates every read
   always_ff @(posedge ftdi_clk) begin
      if (push) mem[wr_ptr] <= {rx_be, rx_data};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge ftdi_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ONE_PTR;
         if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
         case ({push, pop})
            2'b10:   cnt <= cnt + ONE_LVL;
            2'b01:   cnt <= cnt - ONE_LVL;
            default: ;
         endcase
      end
   end

   // FSM state, latched mode, generator, checker and status counters
   always_ff @(posedge ftdi_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         mode_q      <= MODE_LOOP;
         rx_word_cnt <= '0;
         tx_word_cnt <= '0;
         err_cnt     <= '0;
         gen         <= '0;
         exp_word    <= '0;
         pend        <= 1'b0;
      end else begin
         state <= state_nxt;
         if (run_entry) begin
            mode_q      <= mode;
            rx_word_cnt <= '0;
            tx_word_cnt <= '0;
            err_cnt     <= '0;
            gen         <= '0;
            exp_word    <= '0;
            pend        <= 1'b0;
         end else begin
            if (rx_hs) rx_word_cnt <= rx_word_cnt + 32'd1;
            if (tx_hs) tx_word_cnt <= tx_word_cnt + 32'd1;
            if (tx_hs && (mode_q == MODE_SRC)) gen <= gen + ONE_D;
            if (chk_en) begin
               if (mismatch) begin
                  if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                  exp_word <= rx_data + ONE_D;
               end else begin
                  exp_word <= exp_word + ONE_D;
               end
            end
            // A source word left unaccepted when the run stops is held in DRAIN
            if ((state == ST_RUN) && !enable) pend <= (mode_q == MODE_SRC) && !tx_ready;
            else if (tx_hs) pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ft60x_stream_engine.sv
// Bench for ft60x_stream_engine: a 16-bit/DEPTH=16 instance (a_*) and a
// 32-bit/DEPTH=4 instance (b_*) share one clock and reset. Transmitted words
// are checked against an expected queue filled when rx words are accepted.
module tb_ft60x_stream_engine;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // instance A: DATA_W=16, DEPTH=16
   logic        a_enable, a_rx_valid, a_rx_ready, a_tx_valid, a_tx_ready, a_busy;
   logic [1:0]  a_mode, a_rx_be, a_tx_be, a_state;
   logic [15:0] a_rx_data, a_tx_data, a_err;
   logic [4:0]  a_level;
   logic [31:0] a_rx_cnt, a_tx_cnt;

   // instance B: DATA_W=32, DEPTH=4
   logic        b_enable, b_rx_valid, b_rx_ready, b_tx_valid, b_tx_ready, b_busy;
   logic [1:0]  b_mode, b_state;
   logic [3:0]  b_rx_be, b_tx_be;
   logic [31:0] b_rx_data, b_tx_data, b_rx_cnt, b_tx_cnt;
   logic [15:0] b_err;
   logic [2:0]  b_level;

   ft60x_stream_engine #(.DATA_W(16), .DEPTH(16)) u_dut_a (
      .ftdi_clk(clk), .rst_n(rst_n), .enable(a_enable), .mode(a_mode),
      .rx_valid(a_rx_valid), .rx_data(a_rx_data), .rx_be(a_rx_be), .rx_ready(a_rx_ready),
      .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_be(a_tx_be), .tx_ready(a_tx_ready),
      .busy(a_busy), .level(a_level), .rx_word_cnt(a_rx_cnt), .tx_word_cnt(a_tx_cnt),
      .err_cnt(a_err), .fsm_state(a_state)
   );

   ft60x_stream_engine #(.DATA_W(32), .DEPTH(4)) u_dut_b (
      .ftdi_clk(clk), .rst_n(rst_n), .enable(b_enable), .mode(b_mode),
      .rx_valid(b_rx_valid), .rx_data(b_rx_data), .rx_be(b_rx_be), .rx_ready(b_rx_ready),
      .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_be(b_tx_be), .tx_ready(b_tx_ready),
      .busy(b_busy), .level(b_level), .rx_word_cnt(b_rx_cnt), .tx_word_cnt(b_tx_cnt),
      .err_cnt(b_err), .fsm_state(b_state)
   );

   int total = 0;
   int bad   = 0;

   logic [35:0] exp_q[$];

   // generator model for mode 1 on instance A
   logic        a_gen_mode = 1'b0;
   logic [15:0] gen_m = '0;
   int          gen_beats = 0;
   logic        prev_ff = 1'b0;
   logic        wrap_seen = 1'b0;

   logic        a_stall = 1'b0, b_stall = 1'b0;
   logic [17:0] a_held;
   logic [35:0] b_held;
   logic [35:0] a_pop, b_pop;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // monitor A: hold stability, generator model or FIFO scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         a_stall = 1'b0;
      end else begin
         if (a_stall) begin
            check("a_hold_valid", 64'(a_tx_valid), 64'(1));
            check("a_hold_word", 64'({a_tx_be, a_tx_data}), 64'(a_held));
         end
         if (a_tx_valid && a_tx_ready) begin
            if (a_gen_mode) begin
               check("a_gen_word", 64'({a_tx_be, a_tx_data}), 64'({2'b11, gen_m}));
               if (prev_ff && (a_tx_data == 16'h0000)) wrap_seen = 1'b1;
               prev_ff = (a_tx_data == 16'hFFFF);
               gen_m = gen_m + 16'd1;
               gen_beats++;
            end else if (exp_q.size() == 0) begin
               check("a_unexpected_tx", 64'({a_tx_be, a_tx_data}), 64'hDEAD_0000_0000_0000);
            end else begin
               a_pop = exp_q.pop_front();
               check("a_tx_word", 64'({a_tx_be, a_tx_data}), 64'(a_pop));
            end
         end
         a_stall = a_tx_valid && !a_tx_ready;
         a_held  = {a_tx_be, a_tx_data};
      end
   end

   // monitor B: hold stability and FIFO scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         b_stall = 1'b0;
      end else begin
         if (b_stall) begin
            check("b_hold_valid", 64'(b_tx_valid), 64'(1));
            check("b_hold_word", 64'({b_tx_be, b_tx_data}), 64'(b_held));
         end
         if (b_tx_valid && b_tx_ready) begin
            if (exp_q.size() == 0) begin
               check("b_unexpected_tx", 64'({b_tx_be, b_tx_data}), 64'hDEAD_0000_0000_0000);
            end else begin
               b_pop = exp_q.pop_front();
               check("b_tx_word", 64'({b_tx_be, b_tx_data}), 64'(b_pop));
            end
         end
         b_stall = b_tx_valid && !b_tx_ready;
         b_held  = {b_tx_be, b_tx_data};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // offer one word to A until accepted; optionally expect it back on tx
   task automatic a_send(input logic [15:0] d, input logic [1:0] be, input bit push_exp);
      bit hs;
      int n;
      hs = 1'b0;
      n  = 0;
      a_rx_valid = 1'b1;
      a_rx_data  = d;
      a_rx_be    = be;
      while (!hs && n < 100) begin
         @(negedge clk);
         hs = a_rx_ready;
         @(posedge clk);
         #1;
         n++;
      end
      check("a_rx_accept", 64'(hs), 64'(1));
      if (hs && push_exp) exp_q.push_back(36'({be, d}));
      a_rx_valid = 1'b0;
   endtask

   // stream to B for a fixed number of cycles, counting accepted words
   logic [31:0] b_next = 32'h1122_3344;
   task automatic b_stream(input int ncyc, output int acc);
      bit hs;
      logic [3:0] be;
      acc = 0;
      for (int i = 0; i < ncyc; i++) begin
         be = 4'($urandom_range(1, 15));
         b_rx_valid = 1'b1;
         b_rx_data  = b_next;
         b_rx_be    = be;
         @(negedge clk);
         hs = b_rx_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            exp_q.push_back({be, b_next});
            b_next = b_next + 32'd1;
            acc++;
         end
      end
      b_rx_valid = 1'b0;
   endtask

   task automatic a_wait_idle(input int lim);
      int n;
      n = 0;
      while (a_busy && n < lim) begin
         step();
         n++;
      end
      check("a_reach_idle", 64'(a_busy), 64'(0));
   endtask

   task automatic wait_q_empty(input int lim);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < lim) begin
         step();
         n++;
      end
      check("q_drained", 64'(exp_q.size()), 64'(0));
   endtask

   // watchdog: guarantees termination
   initial begin
      #2_000_000;
      bad++;
      $display("FAIL watchdog: got=timeout want=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // main sequence
   initial begin
      int acc;
      int cyc;
      rst_n = 1'b0;
      a_enable = 0; a_mode = 0; a_rx_valid = 0; a_rx_data = 0; a_rx_be = 0; a_tx_ready = 0;
      b_enable = 0; b_mode = 0; b_rx_valid = 0; b_rx_data = 0; b_rx_be = 0; b_tx_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_rx_ready", 64'(a_rx_ready), 64'(0));
      check("rst_a_tx_valid", 64'(a_tx_valid), 64'(0));
      check("rst_a_tx_word",  64'({a_tx_be, a_tx_data}), 64'(0));
      check("rst_a_busy",     64'(a_busy), 64'(0));
      check("rst_a_level",    64'(a_level), 64'(0));
      check("rst_a_cnts",     {a_rx_cnt, a_tx_cnt}, 64'(0));
      check("rst_a_err",      64'(a_err), 64'(0));
      check("rst_b_tx_word",  64'({b_tx_be, b_tx_data}), 64'(0));
      check("rst_b_busy",     64'(b_busy), 64'(0));
      #2 rst_n = 1'b1;
      step();

      // B, mode 0, 32-bit loopback of 20 words
      b_mode = 2'd0; b_enable = 1'b1; b_tx_ready = 1'b1;
      step();
      check("b_run_state", 64'(b_state), 64'(1));
      b_stream(20, acc);
      check("b_acc20", 64'(acc), 64'(20));
      wait_q_empty(20);
      step(); step();
      check("b_rx_cnt20", 64'(b_rx_cnt), 64'(20));
      check("b_tx_cnt20", 64'(b_tx_cnt), 64'(20));
      check("b_level0",   64'(b_level), 64'(0));

      // B, DEPTH=4 fill with output stalled, then release
      b_tx_ready = 1'b0;
      b_stream(8, acc);
      check("b_full_acc",   64'(acc), 64'(4));
      check("b_full_ready", 64'(b_rx_ready), 64'(0));
      check("b_full_level", 64'(b_level), 64'(4));
      b_tx_ready = 1'b1;
      b_stream(4, acc);
      check("b_resume_acc", 64'(acc), 64'(3));
      wait_q_empty(20);
      step(); step();
      check("b_level_end", 64'(b_level), 64'(0));
      check("b_rx_cnt27",  64'(b_rx_cnt), 64'(27));
      check("b_tx_cnt27",  64'(b_tx_cnt), 64'(27));
      b_enable = 1'b0;
      repeat (4) step();
      check("b_idle", 64'(b_busy), 64'(0));

      // A, asynchronous reset mid-run with 10 words queued
      a_mode = 2'd0; a_enable = 1'b1; a_tx_ready = 1'b0;
      step();
      for (int i = 0; i < 10; i++) a_send(16'h0A00 + 16'(i), 2'b11, 1'b1);
      check("a_pre_rst_level", 64'(a_level), 64'(10));
      check("a_pre_rst_rx",    64'(a_rx_cnt), 64'(10));
      #2 rst_n = 1'b0;
      #1;
      check("arst_level",   64'(a_level), 64'(0));
      check("arst_tx_valid", 64'(a_tx_valid), 64'(0));
      check("arst_busy",    64'(a_busy), 64'(0));
      check("arst_cnts",    {a_rx_cnt, a_tx_cnt}, 64'(0));
      check("arst_err",     64'(a_err), 64'(0));
      check("arst_tx_word", 64'({a_tx_be, a_tx_data}), 64'(0));
      exp_q.delete();
      a_enable = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      step();

      // A, mode 2 checker with resync and partial byte enables
      a_mode = 2'd2; a_enable = 1'b1;
      step();
      check("a_chk_state", 64'(a_state), 64'(1));
      a_send(16'd0, 2'b11, 1'b0);
      a_send(16'd1, 2'b11, 1'b0);
      a_send(16'd2, 2'b11, 1'b0);
      a_send(16'd7, 2'b11, 1'b0);
      check("a_err_after_7", 64'(a_err), 64'(1));
      a_send(16'd8, 2'b11, 1'b0);
      a_send(16'd9, 2'b11, 1'b0);
      check("a_err_resync", 64'(a_err), 64'(1));
      check("a_chk_no_tx",  64'(a_tx_valid), 64'(0));
      a_send(16'h55A9, 2'b11, 1'b0);
      check("a_err_2", 64'(a_err), 64'(2));
      a_send(16'h00AA, 2'b01, 1'b0);
      a_send(16'hFFFF, 2'b00, 1'b0);
      a_send(16'h55AB, 2'b11, 1'b0);
      check("a_err_be_mask", 64'(a_err), 64'(2));
      check("a_chk_rx_cnt",  64'(a_rx_cnt), 64'(10));
      a_enable = 1'b0;
      a_wait_idle(10);
      step();
      check("a_err_frozen", 64'(a_err), 64'(2));

      // A, mode 3 drain with 6 queued words and an ignored enable pulse
      a_mode = 2'd3; a_enable = 1'b1; a_tx_ready = 1'b0;
      step();
      for (int i = 0; i < 6; i++) a_send(16'(i), 2'b11, 1'b1);
      check("a_lchk_level", 64'(a_level), 64'(6));
      a_enable = 1'b0;
      step();
      check("a_drain_state", 64'(a_state), 64'(2));
      check("a_drain_rx_ready", 64'(a_rx_ready), 64'(0));
      a_rx_valid = 1'b1; a_rx_data = 16'h7777; a_rx_be = 2'b11;
      a_enable = 1'b1;
      step();
      check("a_drain_pulse_state", 64'(a_state), 64'(2));
      a_enable = 1'b0;
      step();
      check("a_drain_no_accept", 64'(a_level), 64'(6));
      a_rx_valid = 1'b0;
      a_tx_ready = 1'b1;
      a_wait_idle(30);
      check("a_drain_q",      64'(exp_q.size()), 64'(0));
      check("a_drain_tx_cnt", 64'(a_tx_cnt), 64'(6));
      check("a_drain_rx_cnt", 64'(a_rx_cnt), 64'(6));
      check("a_drain_err",    64'(a_err), 64'(0));
      step();
      check("a_stays_idle", 64'(a_busy), 64'(0));

      // A, mode 1 counter source across the 16-bit wrap with stalls
      a_mode = 2'd1; gen_m = '0; gen_beats = 0; a_gen_mode = 1'b1; a_tx_ready = 1'b1;
      a_enable = 1'b1;
      step();
      cyc = 0;
      while (gen_beats < 65545 && cyc < 80000) begin
         a_tx_ready = (gen_beats < 65525) ? 1'b1 : ($urandom_range(0, 2) != 0);
         step();
         cyc++;
      end
      a_tx_ready = 1'b0;
      a_enable = 1'b0;
      step();
      check("a_src_drain_state", 64'(a_state), 64'(2));
      check("a_src_drain_hold",  64'(a_tx_valid), 64'(1));
      step();
      check("a_src_still_hold", 64'(a_tx_valid), 64'(1));
      a_tx_ready = 1'b1;
      a_wait_idle(5);
      check("a_src_wrap", 64'(wrap_seen), 64'(1));
      check("a_src_tx_cnt", 64'(a_tx_cnt), 64'(gen_beats));
      a_gen_mode = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ft60x_stream_engine.md
Name: ft60x_stream_engine

Overview:
- Parametrised data engine between the FT60x bus-side send/receive module and the host-facing logic. It generalises the fixed 16-bit loopback to DATA_W of 16 (FT600) or 32 (FT601), with a configurable internal FIFO depth.
- Adds three run modes besides plain loopback: counter source, counter check, and loopback+check.
- A small run-control FSM with drain handling and status counters supports throughput and integrity testing from the host.

Parameters:
- DATA_W, 16, bus data width in bits; legal values 16 or 32.
- BE_W, DATA_W/8, byte-enable width.
- DEPTH, 512, FIFO depth in words; power of two, minimum 4.
- LVL_W, $clog2(DEPTH)+1, width of the fill-level output.

Ports:
- ftdi_clk  input  1  single clock; all logic is in this domain.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  run request, level-sensitive.
- mode  input  2  0=loopback, 1=counter source, 2=counter check, 3=loopback+check; latched only on IDLE->RUN.
- rx_valid  input  1  word from bus module is valid.
- rx_data  input  DATA_W  received data.
- rx_be  input  BE_W  received byte enables.
- rx_ready  output  1  engine accepts the rx word this cycle.
- tx_valid  output  1  word for the bus module is valid.
- tx_data  output  DATA_W  data to transmit.
- tx_be  output  BE_W  byte enables to transmit.
- tx_ready  input  1  bus module accepts the tx word this cycle.
- busy  output  1  FSM not in IDLE.
- level  output  LVL_W  FIFO occupancy, 0..DEPTH.
- rx_word_cnt  output  32  rx handshakes since RUN entry; wraps.
- tx_word_cnt  output  32  tx handshakes since RUN entry; wraps.
- err_cnt  output  16  checker mismatches; saturates at 16'hFFFF.

Behaviour:
- Handshakes: a transfer occurs on a rising ftdi_clk edge where valid&&ready. The rx side is accepted and counted only on rx_valid&&rx_ready; the tx side advances only on tx_valid&&tx_ready. tx_valid, once asserted, holds with stable tx_data/tx_be until accepted.
- FIFO is first-word-fall-through:
  - tx_data/tx_be show the head word when level>0.
  - Push and pop in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH; full at level==DEPTH, empty at level==0.
  - No overflow is possible, because rx_ready is deasserted when full.
- Reset (asynchronous, any time including mid-transfer): FSM=IDLE, FIFO empty, all counters 0, rx_ready=0, tx_valid=0, tx_data=0, tx_be=0, busy=0, level=0, mode_q=0.
- FSM IDLE:
  - rx_ready=0, tx_valid=0.
  - When enable=1, next cycle is RUN; on that edge: mode_q<=mode, rx/tx/err counters<=0, gen<=0, exp<=0. FIFO contents are retained; FIFO is empty by construction.
- FSM RUN:
  - enable=0 -> DRAIN.
  - Mode 0: rx_ready=!full; rx word pushes to FIFO. tx_valid=!empty, sourced from the FIFO.
  - Mode 1: rx_ready=1, rx words discarded but counted. tx_valid=1, tx_data=gen, tx_be=all ones. gen increments on tx handshake and wraps at 2^DATA_W.
  - Mode 2: rx_ready=1, tx_valid=0. Each rx word is checked (see below).
  - Mode 3: as mode 0, and each accepted rx word is also checked.
  - Check rule: mismatch if ((rx_data ^ exp) & bytemask(rx_be)) != 0.
    - On mismatch: err_cnt++ (saturating), and exp <= rx_data+1 to resync.
    - On match: exp <= exp+1.
    - rx_be=0 words are counted but neither checked nor advance exp.
- FSM DRAIN:
  - rx_ready=0.
  - Modes 0/3: keep presenting the FIFO until empty, then IDLE.
  - Modes 1/2: go to IDLE on the next cycle. In mode 1, if tx_valid was high and not yet accepted, hold it until the handshake completes, then IDLE.
  - enable re-asserted during DRAIN is ignored until IDLE is reached.
- Latency: rx word accepted at edge N appears on tx_data after edge N; tx_valid may assert in the cycle after N (one-cycle minimum loop latency).
- Counters and err_cnt stay frozen (readable) in IDLE until the next RUN entry.

Test Plan:
- Reset mid-RUN with 10 words in FIFO (DATA_W=16) -> level=0, tx_valid=0, busy=0, all counters 0 asynchronously, before the next clock edge.
- Mode 0, DATA_W=32: push 0x11223344..+1 x20 with tx_ready=1 -> identical sequence and BE out, rx_word_cnt=tx_word_cnt=20, level returns to 0.
- Mode 0, DEPTH=4, tx_ready=0, rx_valid=1 continuous -> exactly 4 accepted, rx_ready=0, level=4. Raise tx_ready -> 4 words out in order, rx resumes.
- Mode 1, DATA_W=16, gen preset near wrap by running 65537 beats with random tx_ready stalls -> tx_data sequence wraps 0xFFFF->0x0000, value held stable during stalls.
- Mode 2: send 0,1,2,7,8,9 with rx_be=2'b11 -> err_cnt=1 and no further errors after resync. Send 0x00AA with rx_be=2'b01 against exp=0x55AA -> no error.
- Mode 3 with 6 words queued, drop enable -> rx_ready=0 immediately, remaining 6 words transmitted, then busy=0. enable pulse during DRAIN has no effect.
